// File: rtl/riscv_pkg.sv
// Shared definitions for the load/store unit.
//   - funct3 encodings for RV32I loads and stores
//   - lsu_state_t: LSU sequencing states
//   - acc_size_t plus helpers that decode funct3 into access size / signedness
package riscv_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Any encoding that is not a defined byte/half access falls back to a word.
    function automatic acc_size_t acc_size(input logic we, input logic [2:0] f3);
        acc_size_t sz;
        sz = SZ_WORD;
        if (we) begin
            if (f3 == F3_SB)      sz = SZ_BYTE;
            else if (f3 == F3_SH) sz = SZ_HALF;
        end else begin
            if (f3 == F3_LB || f3 == F3_LBU)      sz = SZ_BYTE;
            else if (f3 == F3_LH || f3 == F3_LHU) sz = SZ_HALF;
        end
        return sz;
    endfunction

    function automatic logic is_unsigned(input logic we, input logic [2:0] f3);
        return !we && (f3 == F3_LBU || f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Memory bus between the LSU (master) and the data memory (slave).
//   mem_req/mem_gnt  : request handshake, request held until granted
//   mem_we, mem_addr, mem_wstrb, mem_wdata : request payload (word address)
//   mem_rvalid/mem_rdata : completion for both loads and stores
interface lsu_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// Load data alignment: picks the byte/half lane from the memory word and
// sign- or zero-extends it to 32 bits.
//   word : raw memory word
//   off  : byte offset within the word (already masked to natural alignment)
//   size : access size
//   uns  : 1 = zero-extend, 0 = sign-extend
//   data : aligned, extended result
module lsu_align
    import riscv_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  acc_size_t   size,
    input  logic        uns,
    output logic [31:0] data
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[8*off +: 8];
        half_lane = off[1] ? word[31:16] : word[15:0];
        data      = word;
        case (size)
            SZ_BYTE: data = {{24{byte_lane[7] & ~uns}}, byte_lane};
            SZ_HALF: data = {{16{half_lane[15] & ~uns}}, half_lane};
            default: data = word;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: turns one datapath load/store into a single memory bus
// transaction, stalling the core until the access completes.
//   clk, rst_n      : clock, asynchronous active-low reset
//   req_valid/req_we/funct3/addr/wdata : request from the datapath
//   rdata           : aligned load result, valid only in DONE (0 otherwise)
//   stall           : hold the core while a request is pending
//   misalign        : one-cycle misaligned-access flag
//   bus             : memory bus (lsu_if master)
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned half/word
// accesses skip the bus and complete in DONE with misalign=1. Without it the
// low address bits are masked to the natural alignment and misalign stays 0.
//
// state | meaning
// IDLE  | waiting for req_valid; request is captured on acceptance
// REQ   | mem_req asserted until mem_gnt
// WAIT  | waiting for mem_rvalid, load data captured
// DONE  | stall low, rdata presented for one cycle
module lsu
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misalign,
    lsu_if.master             bus
);
    lsu_state_t        state, state_nxt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [ADDR_W-1:2] waddr_q;
    logic [31:0]       rdata_q;
    logic              mis_q;
    logic              mis_in;
    acc_size_t         size_in, size_q;
    logic [1:0]        off_eff;
    logic [3:0]        strb;
    logic [31:0]       wrep;
    logic [31:0]       aligned;

    assign size_in = acc_size(req_we, funct3);
    assign size_q  = acc_size(we_q, f3_q);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_in = (size_in == SZ_HALF && addr[0]) ||
                    (size_in == SZ_WORD && addr[1:0] != 2'b00);
`else
    assign mis_in = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = mis_in ? DONE : REQ;
            REQ:  if (bus.mem_gnt) state_nxt = WAIT;
            WAIT: if (bus.mem_rvalid) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            waddr_q <= '0;
            rdata_q <= 32'h0;
            mis_q   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                f3_q    <= funct3;
                off_q   <= addr[1:0];
                waddr_q <= addr[ADDR_W-1:2];
                rdata_q <= 32'h0;
                mis_q   <= mis_in;
            end else if (state == WAIT && bus.mem_rvalid) begin
                // Store completions return data too; it is dropped here.
                rdata_q <= we_q ? 32'h0 : bus.mem_rdata;
            end
        end
    end

    // Mask the offset to the natural alignment of the access size.
    always_comb begin
        off_eff = off_q;
        case (size_q)
            SZ_HALF: off_eff = {off_q[1], 1'b0};
            SZ_WORD: off_eff = 2'b00;
            default: off_eff = off_q;
        endcase
    end

    always_comb begin
        strb = 4'b1111;
        wrep = wdata;
        case (size_q)
            SZ_BYTE: begin
                strb = 4'b0001 << off_eff;
                wrep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                strb = off_eff[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata[15:0]}};
            end
            default: begin
                strb = 4'b1111;
                wrep = wdata;
            end
        endcase
    end

    assign bus.mem_req   = (state == REQ);
    assign bus.mem_we    = (state == REQ) && we_q;
    assign bus.mem_addr  = (state == REQ) ? {waddr_q, 2'b00} : '0;
    assign bus.mem_wstrb = (state == REQ && we_q) ? strb : 4'b0000;
    assign bus.mem_wdata = (state == REQ && we_q) ? wrep : 32'h0;

    lsu_align u_align (
        .word (rdata_q),
        .off  (off_eff),
        .size (size_q),
        .uns  (is_unsigned(we_q, f3_q)),
        .data (aligned)
    );

    assign stall    = (state == IDLE && req_valid) || state == REQ || state == WAIT;
    assign rdata    = (state == DONE && !mis_q) ? aligned : 32'h0;
    assign misalign = (state == DONE) && mis_q;
endmodule

// File: tb/tb_lsu.sv
module tb_lsu;
    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;

    lsu_if #(.ADDR_W(32)) bus ();

    lsu #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_we    (req_we),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .misalign  (misalign),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] mrd;
        int          gl;
        int          rl;
        logic [31:0] e_rd;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic        e_mis;
    } tv_t;

    tv_t tv[$];
    tv_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic tv_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] wd, input logic [31:0] mrd, input int gl,
                               input int rl, input logic [31:0] e_rd, input logic [31:0] e_addr,
                               input logic [3:0] e_strb, input logic [31:0] e_wd, input logic e_mis);
        tv_t t;
        t.we = we; t.f3 = f3; t.a = a; t.wd = wd; t.mrd = mrd; t.gl = gl; t.rl = rl;
        t.e_rd = e_rd; t.e_addr = e_addr; t.e_strb = e_strb; t.e_wd = e_wd; t.e_mis = e_mis;
        return t;
    endfunction

    task automatic run_op(input tv_t t);
        int cyc, req_cyc, wait_cyc, e_done, e_req;
        bit granted, done;
        tv_t e;
        cyc = 0; req_cyc = 0; wait_cyc = 0; granted = 0; done = 0;
        e_done = t.e_mis ? 1 : t.gl + t.rl + 1;
        e_req  = t.e_mis ? 0 : t.gl;
        sb.push_back(t);
        @(negedge clk);
        req_valid = 1'b1; req_we = t.we; funct3 = t.f3; addr = t.a; wdata = t.wd;
        #1;
        chk("stall_accept", {31'b0, stall}, 32'd1);
        while (!done && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
            e = sb[0];
            if (!stall) begin
                done = 1;
                chk("done_cycle", cyc, e_done);
                chk("rdata", rdata, e.e_rd);
                chk("misalign", {31'b0, misalign}, {31'b0, e.e_mis});
                chk("req_cycles", req_cyc, e_req);
                void'(sb.pop_front());
            end else begin
                if (rdata !== 32'h0) chk("rdata_stalled", rdata, 32'h0);
                if (bus.mem_req) begin
                    req_cyc++;
                    chk("mem_addr", bus.mem_addr, e.e_addr);
                    if (req_cyc == 1) begin
                        chk("mem_we", {31'b0, bus.mem_we}, {31'b0, e.we});
                        chk("mem_wstrb", {28'b0, bus.mem_wstrb}, {28'b0, e.e_strb});
                        chk("mem_wdata", bus.mem_wdata, e.e_wd);
                    end
                    if (req_cyc == t.gl) begin
                        bus.mem_gnt = 1'b1; granted = 1;
                    end else begin
                        // stray completion while still requesting must be ignored
                        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5A5A5A5A;
                    end
                end else if (granted) begin
                    wait_cyc++;
                    if (wait_cyc == t.rl) begin
                        bus.mem_rvalid = 1'b1; bus.mem_rdata = t.mrd;
                    end else begin
                        bus.mem_gnt = 1'b1;
                    end
                end
            end
        end
        if (!done) chk("timeout", cyc, e_done);
        @(negedge clk);
        req_valid = 1'b0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        #1;
        chk("idle_stall", {31'b0, stall}, 32'd0);
        chk("idle_rdata", rdata, 32'h0);
        chk("idle_misalign", {31'b0, misalign}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;

        //        we  f3      addr          wdata         mem_rdata    gl rl  rdata         mem_addr      strb     mem_wdata    mis
        tv.push_back(mk(0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 1, 1, 32'hDEADBEEF, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(0, 3'b000, 32'h103, 32'h0,        32'h80112233, 1, 1, 32'hFFFFFF80, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(0, 3'b100, 32'h103, 32'h0,        32'h80112233, 1, 1, 32'h00000080, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(1, 3'b001, 32'h102, 32'h0000ABCD, 32'h12345678, 1, 1, 32'h0,        32'h100, 4'b1100, 32'hABCDABCD, 0));
        tv.push_back(mk(0, 3'b010, 32'h200, 32'h0,        32'hCAFEF00D, 5, 3, 32'hCAFEF00D, 32'h200, 4'b0000, 32'h0,        0));
        tv.push_back(mk(0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 2, 1, 32'hFFFF8001, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(0, 3'b101, 32'h100, 32'h0,        32'h8001F00F, 1, 2, 32'h0000F00F, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(0, 3'b000, 32'h101, 32'h0,        32'h00007F00, 1, 1, 32'h0000007F, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(1, 3'b000, 32'h105, 32'h000000A5, 32'hFFFFFFFF, 1, 1, 32'h0,        32'h104, 4'b0010, 32'hA5A5A5A5, 0));
        tv.push_back(mk(1, 3'b010, 32'h108, 32'h11223344, 32'h0,        3, 1, 32'h0,        32'h108, 4'b1111, 32'h11223344, 0));
        tv.push_back(mk(0, 3'b011, 32'h10C, 32'h0,        32'h89ABCDEF, 1, 1, 32'h89ABCDEF, 32'h10C, 4'b0000, 32'h0,        0));
`ifdef LSU_MISALIGN_TRAP_EN
        tv.push_back(mk(0, 3'b010, 32'h102, 32'h0,        32'h01020304, 1, 1, 32'h0,        32'h0,     4'b0000, 32'h0,        1));
        tv.push_back(mk(0, 3'b001, 32'h103, 32'h0,        32'h12345678, 1, 1, 32'h0,        32'h0,     4'b0000, 32'h0,        1));
        tv.push_back(mk(1, 3'b010, 32'h101, 32'h0BADF00D, 32'h0,        1, 1, 32'h0,        32'h0,     4'b0000, 32'h0,        1));
`else
        tv.push_back(mk(0, 3'b010, 32'h102, 32'h0,        32'h01020304, 1, 1, 32'h01020304, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(0, 3'b001, 32'h103, 32'h0,        32'h12345678, 1, 1, 32'h00001234, 32'h100, 4'b0000, 32'h0,        0));
        tv.push_back(mk(1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0,        1, 1, 32'h0,        32'h100, 4'b0011, 32'hBEEFBEEF, 0));
`endif

        #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        chk("rst_mem_wstrb", {28'b0, bus.mem_wstrb}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) run_op(tv[i]);

        // Reset while waiting for rvalid, then a late rvalid must be ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h300;
        @(negedge clk);
        chk("mid_req", {31'b0, bus.mem_req}, 32'd1);
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        chk("mid_wait_stall", {31'b0, stall}, 32'd1);
        chk("mid_wait_req", {31'b0, bus.mem_req}, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", {31'b0, bus.mem_req}, 32'd0);
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
        chk("late_rvalid_stall", {31'b0, stall}, 32'd0);
        chk("late_rvalid_rdata", rdata, 32'h0);
        chk("late_rvalid_req", {31'b0, bus.mem_req}, 32'd0);

        run_op(mk(0, 3'b010, 32'h400, 32'h0, 32'h76543210, 1, 1, 32'h76543210, 32'h400, 4'b0000, 32'h0, 0));

        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
